// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - hazard controller signal bundle
//
// Purpose: groups the pipeline-side inputs (register ids, load/branch/memory/halt
// status) and the control outputs (write enables, flushes, freeze, status and
// statistics) of hazard_controller.
// Modports:
//   master - pipeline side: drives hazard inputs, observes controls
//   slave  - hazard_controller side: observes hazard inputs, drives controls
// Parameters: REG_ADDR_W register-address width, CNT_W statistics width.

interface hazard_controller_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_ex_memread;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic                  ex_branch_taken;
    logic                  mem_busy;
    logic                  wb_halt;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  pipe_en;
    logic                  halted;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [CNT_W-1:0]      memwait_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_ex_memread, id_ex_rd,
               ex_branch_taken, mem_busy, wb_halt,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en,
               halted, mem_timeout, stall_cnt, flush_cnt, memwait_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_ex_memread, id_ex_rd,
               ex_branch_taken, mem_busy, wb_halt,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en,
               halted, mem_timeout, stall_cnt, flush_cnt, memwait_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / branch / memory-wait stall sequencer
//
// Purpose: Mealy hazard FSM (RUN, LDSTALL, MWAIT, HALTED) producing PC and IF/ID
// write enables, IF/ID and ID/EX flushes, a global pipe enable, a halted flag
// and a sticky memory-timeout flag.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   hif   - hazard_controller_if.slave (hazard inputs in, controls out)
// Optional feature: macro HAZARD_STATS_EN enables the saturating stall_cnt,
// flush_cnt and memwait_cnt counters; without it those outputs are tied to 0.

module hazard_controller #(
    parameter int REG_ADDR_W   = 3,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave hif
);
    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    // Entering MWAIT already accounts for the first busy cycle, so a busy MWAIT
    // cycle whose counter holds MAX-1 is the MAX-th consecutive busy cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {RUN, LDSTALL, MWAIT, HALTED} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  hz;
    logic                  pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic                  pipe_en, halted;

    assign ex_rd = hif.id_ex_rd;
    assign hz    = hif.id_ex_memread &
                   ((hif.id_uses_rs & (hif.id_rs == ex_rd)) |
                    (hif.id_uses_rt & (hif.id_rt == ex_rd)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_en     = 1'b1;
        halted      = 1'b0;

        if (state_q == HALTED) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
            halted      = 1'b1;
        end else if (hif.wb_halt) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
            wait_cnt_d  = '0;
            state_d     = HALTED;
        end else if (hif.mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
            if (state_q == MWAIT) begin
                if (wait_cnt_q >= WAIT_LAST) begin
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = HALTED;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end else begin
                wait_cnt_d = WAIT_ONE;
                state_d    = MWAIT;
            end
        end else begin
            // RUN, LDSTALL or the MWAIT release cycle
            wait_cnt_d = '0;
            state_d    = RUN;
            if (hif.ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (hz && (state_q != LDSTALL)) begin
                // ID/EX already holds the bubble while in LDSTALL
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                state_d     = LDSTALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hif.pc_write    = pc_write;
    assign hif.if_id_write = if_id_write;
    assign hif.if_id_flush = if_id_flush;
    assign hif.id_ex_flush = id_ex_flush;
    assign hif.pipe_en     = pipe_en;
    assign hif.halted      = halted;
    assign hif.mem_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (state_q != HALTED) begin
            if (id_ex_flush && !if_id_flush && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (if_id_flush && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            if (!pipe_en && ((state_q == MWAIT) || (state_d == MWAIT)) &&
                (memwait_cnt_q != '1))
                memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign hif.stall_cnt   = stall_cnt_q;
    assign hif.flush_cnt   = flush_cnt_q;
    assign hif.memwait_cnt = memwait_cnt_q;
`else
    assign hif.stall_cnt   = {CNT_W{1'b0}};
    assign hif.flush_cnt   = {CNT_W{1'b0}};
    assign hif.memwait_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller

module tb_hazard_controller;
    localparam int MAXW = 15;

    logic clk;
    logic reset;

    hazard_controller_if #(.REG_ADDR_W(3), .CNT_W(16)) hif ();

    hazard_controller #(.REG_ADDR_W(3), .MEM_WAIT_MAX(MAXW), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [2:0] rd;
        logic       br;
        logic       busy;
        logic       halt;
        logic [6:0] exp;   // {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_en, halted, mem_timeout}
    } vec_t;

    localparam logic [6:0] E_NORM  = 7'b1100100;
    localparam logic [6:0] E_STALL = 7'b0001100;
    localparam logic [6:0] E_BR    = 7'b1111100;
    localparam logic [6:0] E_FRZ   = 7'b0000000;
    localparam logic [6:0] E_HLT   = 7'b0000010;
    localparam logic [6:0] E_HLTTO = 7'b0000011;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_halted, m_tmo, m_bubble;
    int m_busy_run;
    int m_st, m_fl, m_mw;

    function automatic vec_t mk(logic rst, logic [2:0] rs, logic [2:0] rt, logic urs, logic urt,
                                logic mr, logic [2:0] rd, logic br, logic busy, logic halt,
                                logic [6:0] e);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
        v.rd = rd; v.br = br; v.busy = busy; v.halt = halt; v.exp = e;
        return v;
    endfunction

    function automatic vec_t idle(logic [6:0] e);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endfunction

    function automatic vec_t busy(logic [6:0] e);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, e);
    endfunction

    function automatic vec_t ldu(logic [6:0] e);
        return mk(0, 3, 0, 1, 0, 1, 3, 0, 0, 0, e);
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, logic [6:0] exp);
        logic [6:0] act;
        string nm[7];
        nm = '{"pc_write", "if_id_write", "if_id_flush", "id_ex_flush", "pipe_en", "halted", "mem_timeout"};
        act = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_flush,
               hif.pipe_en, hif.halted, hif.mem_timeout};
        for (int k = 0; k < 7; k++)
            chk($sformatf("%s.%s", tag, nm[k]), 16'(act[6-k]), 16'(exp[6-k]));
    endtask

    task automatic drive(vec_t v);
        reset               = v.rst;
        hif.id_rs           = v.rs;
        hif.id_rt           = v.rt;
        hif.id_uses_rs      = v.urs;
        hif.id_uses_rt      = v.urt;
        hif.id_ex_memread   = v.mr;
        hif.id_ex_rd        = v.rd;
        hif.ex_branch_taken = v.br;
        hif.mem_busy        = v.busy;
        hif.wb_halt         = v.halt;
    endtask

    // Inputs are applied 1ns after a rising edge; Mealy outputs checked at the falling edge.
    task automatic step(vec_t v, string tag);
        drive(v);
        #4;
        if (!v.rst) check_outs(tag, v.exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] model_out(vec_t v);
        bit hz;
        hz = v.mr && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
        if (m_halted)                return {5'b00000, 1'b1, m_tmo};
        if (v.halt || v.busy)        return {5'b00000, 1'b0, m_tmo};
        if (v.br)                    return {5'b11111, 1'b0, m_tmo};
        if (hz && !m_bubble)         return {5'b00011, 1'b0, m_tmo};
        return {5'b11001, 1'b0, m_tmo};
    endfunction

    task automatic model_update(vec_t v, logic [6:0] e);
        bit hz;
        hz = v.mr && ((v.urs && v.rs == v.rd) || (v.urt && v.rt == v.rd));
        if (v.rst) begin
            m_halted = 0; m_tmo = 0; m_bubble = 0; m_busy_run = 0;
            m_st = 0; m_fl = 0; m_mw = 0;
        end else if (!m_halted) begin
            if (e[3] && !e[4]) m_st++;
            if (e[4]) m_fl++;
            if (!e[2] && (m_busy_run > 0 || (v.busy && !v.halt))) m_mw++;
            if (v.halt) begin
                m_halted = 1;
            end else if (v.busy) begin
                m_busy_run++;
                m_bubble = 0;
                if (m_busy_run >= MAXW) begin
                    m_halted = 1;
                    m_tmo = 1;
                end
            end else begin
                m_busy_run = 0;
                m_bubble = !v.br && hz && !m_bubble;
            end
        end
    endtask

    task automatic check_stats(string tag, int st, int fl, int mw);
`ifdef HAZARD_STATS_EN
        chk({tag, ".stall_cnt"}, hif.stall_cnt, 16'(st));
        chk({tag, ".flush_cnt"}, hif.flush_cnt, 16'(fl));
        chk({tag, ".memwait_cnt"}, hif.memwait_cnt, 16'(mw));
`else
        chk({tag, ".stall_cnt"}, hif.stall_cnt, 16'(st * 0));
        chk({tag, ".flush_cnt"}, hif.flush_cnt, 16'(fl * 0));
        chk({tag, ".memwait_cnt"}, hif.memwait_cnt, 16'(mw * 0));
`endif
    endtask

    vec_t tbl[$];
    vec_t rst_v;

    initial begin
        rst_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_FRZ);
        drive(rst_v);
        @(posedge clk);
        #1;

        // ---- directed table ----
        tbl.push_back(rst_v);
        tbl.push_back(idle(E_NORM));                                  // reset state
        tbl.push_back(ldu(E_STALL));                                  // load-use cycle 0
        tbl.push_back(ldu(E_NORM));                                   // LDSTALL: no 2nd bubble
        tbl.push_back(ldu(E_STALL));                                  // back in RUN
        tbl.push_back(idle(E_NORM));
        tbl.push_back(mk(0, 5, 5, 0, 1, 1, 5, 0, 0, 0, E_STALL));     // rt hazard
        tbl.push_back(mk(0, 5, 5, 0, 1, 1, 5, 1, 0, 0, E_BR));        // branch in LDSTALL
        tbl.push_back(mk(0, 2, 0, 1, 0, 1, 2, 1, 0, 0, E_BR));        // branch beats hz
        tbl.push_back(mk(0, 2, 0, 1, 0, 1, 2, 0, 0, 0, E_STALL));     // still RUN
        tbl.push_back(idle(E_NORM));
        tbl.push_back(mk(0, 4, 0, 0, 0, 1, 4, 0, 0, 0, E_NORM));      // rs not used
        tbl.push_back(mk(0, 4, 0, 1, 0, 0, 4, 0, 0, 0, E_NORM));      // not a load
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, E_STALL));     // R0 not special
        tbl.push_back(idle(E_NORM));
        for (int k = 0; k < 4; k++) tbl.push_back(busy(E_FRZ));       // 4-cycle wait
        tbl.push_back(idle(E_NORM));                                  // release
        tbl.push_back(busy(E_FRZ));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 1, 1, 0, E_FRZ));       // branch+hz during freeze
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, E_STALL));     // hz acts at release
        tbl.push_back(busy(E_FRZ));                                   // LDSTALL then busy
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR));        // branch acts at release
        tbl.push_back(ldu(E_STALL));
        tbl.push_back(mk(1, 3, 0, 1, 0, 1, 3, 0, 0, 0, E_FRZ));       // reset mid-stall
        tbl.push_back(ldu(E_STALL));                                  // RUN again, not LDSTALL
        tbl.push_back(idle(E_NORM));
        tbl.push_back(busy(E_FRZ));
        tbl.push_back(rst_v);                                         // reset mid-wait
        tbl.push_back(idle(E_NORM));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ));       // halt + busy: halt wins
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_HLT));       // branch ignored
        tbl.push_back(busy(E_HLT));
        tbl.push_back(ldu(E_HLT));
        tbl.push_back(rst_v);
        tbl.push_back(idle(E_NORM));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("row%0d", i));

        // ---- timeout boundary: 14 busy cycles survive, 15 time out ----
        for (int k = 0; k < MAXW - 1; k++) step(busy(E_FRZ), $sformatf("w14_%0d", k));
        step(idle(E_NORM), "w14_release");
        for (int k = 0; k < MAXW; k++) step(busy(E_FRZ), $sformatf("w15_%0d", k));
        step(idle(E_HLTTO), "timeout");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_HLTTO), "timeout_hold_br");
        step(busy(E_HLTTO), "timeout_hold_busy");
        step(rst_v, "rst");
        step(idle(E_NORM), "timeout_cleared");

        // ---- statistics scenario ----
        step(rst_v, "rst");
        step(ldu(E_STALL), "st_ld1");
        step(idle(E_NORM), "st_i1");
        step(ldu(E_STALL), "st_ld2");
        step(idle(E_NORM), "st_i2");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR), "st_br");
        for (int k = 0; k < 3; k++) step(busy(E_FRZ), $sformatf("st_busy%0d", k));
        step(idle(E_NORM), "st_rel");
        check_stats("stats", 2, 1, 3);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_FRZ), "st_halt");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_HLT), "st_halted_br");
        check_stats("stats_frozen", 2, 1, 3);

        // ---- randomized against the reference model ----
        step(rst_v, "rst");
        model_update(rst_v, E_FRZ);
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            logic [6:0] e;
            bit burst;
            burst  = (i % 256) < 20;
            v.rst  = ($urandom_range(0, 79) == 0);
            v.rs   = 3'($urandom_range(0, 7));
            v.rt   = 3'($urandom_range(0, 7));
            v.urs  = 1'($urandom_range(0, 1));
            v.urt  = 1'($urandom_range(0, 1));
            v.mr   = 1'($urandom_range(0, 1));
            v.rd   = 3'($urandom_range(0, 3));
            v.br   = ($urandom_range(0, 5) == 0);
            v.busy = burst || ($urandom_range(0, 3) == 0);
            v.halt = !burst && ($urandom_range(0, 149) == 0);
            e = model_out(v);
            v.exp = e;
            step(v, $sformatf("rnd%0d", i));
            model_update(v, e);
`ifdef HAZARD_STATS_EN
            if (!v.rst && (i % 50 == 0)) check_stats($sformatf("rnd%0d", i), m_st, m_fl, m_mw);
`endif
        end
        check_stats("rnd_end", m_st, m_fl, m_mw);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and stall sequencer for the 5-stage SIMPLE core; works alongside the forwarding unit.
- Detects load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Drives PC/IF-ID write enables, bubble and flush controls, and a global pipeline freeze.
- Keeps a small FSM to suppress double-stalling, time out stuck memory accesses and latch a halted state.

Parameters:
- REG_ADDR_W, 3, register-address width (8 GPRs)
- MEM_WAIT_MAX, 15, maximum consecutive mem_busy cycles before timeout; legal range 1..255
- CNT_W, 16, statistics counter width (only used with HAZARD_STATS_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  REG_ADDR_W  source register A of instruction in ID
- id_rt  in  REG_ADDR_W  source register B of instruction in ID
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rd  in  REG_ADDR_W  destination register of instruction in EX
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory has not completed its access this cycle
- wb_halt  in  1  HLT instruction is in WB
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  load bubble (NOP) into ID/EX
- pipe_en  out  1  global enable for ID/EX, EX/MEM, MEM/WB
- halted  out  1  core stopped
- mem_timeout  out  1  sticky; a memory wait exceeded MEM_WAIT_MAX
- stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  statistics (see Optional Feature)

Behaviour:
- States: RUN, LDSTALL, MWAIT, HALTED. Outputs are Mealy: a function of the current state and current inputs.
- Reset (clk edge with reset=1):
  - state=RUN, wait counter=0, mem_timeout=0, statistics=0.
  - In RUN with idle inputs: pc_write=1, if_id_write=1, pipe_en=1, all flushes=0, halted=0.
- Load-use hazard term: hz = id_ex_memread & ((id_uses_rs & id_rs==id_ex_rd) | (id_uses_rt & id_rt==id_ex_rd)). R0 is not special-cased.
- Priority, evaluated each cycle in RUN and LDSTALL:
  - wb_halt: all enables 0, flushes 0; next state HALTED.
  - else mem_busy: pc_write=0, if_id_write=0, pipe_en=0, flushes 0 (full freeze); next state MWAIT, wait counter=1.
  - else ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1, pipe_en=1; next state RUN. Branch beats hz because the ID instruction is on the wrong path.
  - else hz, and only while in RUN: pc_write=0, if_id_write=0, id_ex_flush=1, pipe_en=1; next state LDSTALL.
  - else normal flow; next state RUN.
- LDSTALL:
  - Lasts exactly one cycle. hz is ignored, because ID/EX now holds the bubble.
  - Normal flow otherwise; returns to RUN.
- MWAIT:
  - Full freeze while mem_busy=1; wait counter increments each cycle.
  - If the counter reaches MEM_WAIT_MAX with mem_busy still 1: set mem_timeout, go to HALTED.
  - On mem_busy=0: same cycle behaves as RUN priority minus the mem_busy term (branch or hz may act); counter cleared.
  - A branch or hazard seen during the freeze is not acted on until the release cycle.
- HALTED:
  - halted=1, pc_write=if_id_write=pipe_en=0, flushes 0.
  - Left only by reset; all inputs are ignored.
- Simultaneous wb_halt and mem_busy: halt wins.
- Reset asserted mid-stall or mid-wait: returns to RUN next edge, with no residual bubble or flush.
- Wait counter width is ceil(log2(MEM_WAIT_MAX+1)); it never wraps.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_cnt +1 per cycle with id_ex_flush=1 and if_id_flush=0.
  - flush_cnt +1 per cycle with if_id_flush=1.
  - memwait_cnt +1 per cycle with pipe_en=0 in MWAIT or entering it.
  - All counters saturate at 2^CNT_W-1, clear on reset, and freeze in HALTED.
- Undefined: the three outputs are tied to 0 and no counter flops exist.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=3, id_rs=3, id_uses_rs=1.
  - Cycle 0: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Cycle 1 (LDSTALL), same inputs: normal flow, no second bubble.
- Branch vs hazard: ex_branch_taken=1 with hz=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1; state stays RUN.
- Memory wait: mem_busy=1 for 4 cycles, then 0.
  - 4 cycles with pipe_en=0, pc_write=0.
  - Release cycle normal; counter back to 0.
- Timeout (MEM_WAIT_MAX=15): mem_busy held high.
  - mem_timeout=1 and halted=1 after cycle 15.
  - Both persist until reset; reset clears them.
- Halt: wb_halt=1 together with mem_busy=1 -> HALTED next cycle; later ex_branch_taken=1 causes no flush.
- HAZARD_STATS_EN: 2 load stalls, 1 branch, 3-cycle mem wait -> stall_cnt=2, flush_cnt=1, memwait_cnt=3.
